// File: rtl/free_list_ctrl.sv
// rtl/free_list_ctrl.sv - physical-register free-list circular queue controller
// Seeds the tag storage after reset, then pops free tags at head and pushes released tags at tail.
module free_list_ctrl #(
  parameter int DEPTH     = 64,
  parameter int INDEX     = 6,
  parameter int WIDTH     = 7,
  parameter int INIT_BASE = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushTag_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popTag_o,
  output logic             ready_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [INDEX:0]   count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [INDEX-1:0] ramRdAddr_o,
  input  logic [WIDTH-1:0] ramRdData_i,
  output logic             ramWe_o,
  output logic [INDEX-1:0] ramWrAddr_o,
  output logic [WIDTH-1:0] ramWrData_o
);

  typedef enum logic {S_INIT, S_READY} state_t;

  localparam logic [INDEX:0]   FULL_CNT = (INDEX+1)'(DEPTH);
  localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [INDEX-1:0] r_init_cnt;
  logic [INDEX-1:0] r_head;
  logic [INDEX-1:0] r_tail;
  logic [INDEX:0]   r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_ready;
  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_ready = (r_state == S_READY);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == S_INIT && r_init_cnt == LAST_IDX) w_next_state = S_READY;
  end

  // Only the write port changes with state; the read side always tracks head.
  always_comb begin
    w_pop_ok    = w_ready & pop_i & ~w_empty;
    w_push_ok   = w_ready & push_i & (~w_full | w_pop_ok);
    ramWe_o     = 1'b0;
    ramWrAddr_o = r_tail;
    ramWrData_o = pushTag_i;
    if (r_state == S_INIT) begin
      ramWe_o     = 1'b1;
      ramWrAddr_o = r_init_cnt;
      ramWrData_o = WIDTH'(INIT_BASE) + WIDTH'(r_init_cnt);
    end else if (w_push_ok) begin
      ramWe_o     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_cnt  <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (r_init_cnt == LAST_IDX) begin
        r_count <= FULL_CNT;
        r_head  <= '0;
        r_tail  <= '0;
      end
    end else begin
      if (w_pop_ok)  r_head <= r_head + 1'b1;
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (push_i & ~w_push_ok) r_overflow  <= 1'b1;
      if (pop_i & w_empty)     r_underflow <= 1'b1;
    end
  end

  assign ramRdAddr_o = r_head;
  assign popTag_o    = ramRdData_i;
  assign ready_o     = w_ready;
  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule

// File: tb/tb_free_list_ctrl.sv
// tb/tb_free_list_ctrl.sv - randomized self-checking bench for free_list_ctrl
// The free list is modelled as a plain tag queue; the storage array lives here.
module tb_free_list_ctrl;
  localparam int DEPTH = 64;
  localparam int INDEX = 6;
  localparam int WIDTH = 7;
  localparam int INIT_BASE = 32;

  logic             clk = 1'b0;
  logic             reset, push_i, pop_i;
  logic [WIDTH-1:0] pushTag_i, popTag_o, ramRdData_i, ramWrData_o;
  logic             ready_o, empty_o, full_o, overflow_o, underflow_o, ramWe_o;
  logic [INDEX:0]   count_o;
  logic [INDEX-1:0] ramRdAddr_o, ramWrAddr_o;

  always #5 clk = ~clk;

  free_list_ctrl #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .INIT_BASE(INIT_BASE)) dut (
    .clk(clk), .reset(reset), .push_i(push_i), .pushTag_i(pushTag_i), .pop_i(pop_i),
    .popTag_o(popTag_o), .ready_o(ready_o), .empty_o(empty_o), .full_o(full_o),
    .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .ramRdAddr_o(ramRdAddr_o), .ramRdData_i(ramRdData_i), .ramWe_o(ramWe_o),
    .ramWrAddr_o(ramWrAddr_o), .ramWrData_o(ramWrData_o)
  );

  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (ramWe_o) begin
      ram[ramWrAddr_o] <= ramWrData_o;
    end
  end
  assign ramRdData_i = ram[ramRdAddr_o];

  int n_vec = 0;
  int n_err = 0;

  int m_q[$];
  bit m_ovf, m_unf;
  int m_pushes, m_pops;
  int p_count, p_head;
  bit p_ovf, p_unf;
  bit e_we, e_tag_valid;
  int e_waddr, e_wdata, e_tag;

  // Drive one READY cycle and advance the reference queue.
  task automatic cyc(input bit p, input int t, input bit q);
    bit pop_ok, push_ok;
    @(negedge clk);
    push_i = p; pushTag_i = WIDTH'(t); pop_i = q;
    #1;
    p_count = m_q.size(); p_ovf = m_ovf; p_unf = m_unf; p_head = m_pops % DEPTH;
    e_tag_valid = (m_q.size() > 0);
    e_tag = e_tag_valid ? m_q[0] : 0;
    pop_ok  = q && (m_q.size() > 0);
    push_ok = p && ((m_q.size() < DEPTH) || pop_ok);
    e_we = push_ok; e_waddr = m_pushes % DEPTH; e_wdata = t;
    if (p && !push_ok) m_ovf = 1'b1;
    if (q && m_q.size() == 0) m_unf = 1'b1;
    if (pop_ok) begin void'(m_q.pop_front()); m_pops++; end
    if (push_ok) begin m_q.push_back(t); m_pushes++; end
  endtask

  task automatic run_init(input int n);
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      push_i = 1'(($urandom)); pop_i = 1'($urandom); pushTag_i = WIDTH'($urandom);
      #1;
      n_vec++;
      if (ramWe_o !== 1'b1 || ramWrAddr_o !== INDEX'(c) || ramWrData_o !== WIDTH'(INIT_BASE + c)
          || ready_o !== 1'b0 || count_o !== '0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
        n_err++;
        $display("FAIL init_write c=%0d: we=%b addr=%0d data=%0d ready=%b count=%0d ovf=%b unf=%b, want 1/%0d/%0d/0/0/0/0",
                 c, ramWe_o, ramWrAddr_o, ramWrData_o, ready_o, count_o, overflow_o, underflow_o, c, INIT_BASE + c);
      end
    end
    if (n == DEPTH) begin
      @(negedge clk);
      push_i = 1'b0; pop_i = 1'b0;
      #1;
      n_vec++;
      if (ready_o !== 1'b1 || count_o !== 7'(DEPTH) || full_o !== 1'b1 || empty_o !== 1'b0) begin
        n_err++;
        $display("FAIL init_done: ready=%b count=%0d full=%b empty=%b, want 1/%0d/1/0",
                 ready_o, count_o, full_o, empty_o, DEPTH);
      end
      m_q.delete();
      for (int i = 0; i < DEPTH; i++) m_q.push_back(INIT_BASE + i);
      m_pushes = 0; m_pops = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    reset = 1'b1; push_i = 1'b0; pop_i = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (ready_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0 || overflow_o !== 1'b0
        || underflow_o !== 1'b0 || count_o !== '0 || ramWrAddr_o !== '0 || ramRdAddr_o !== '0) begin
      n_err++;
      $display("FAIL %s: ready=%b empty=%b full=%b ovf=%b unf=%b count=%0d waddr=%0d raddr=%0d, want 0/1/0/0/0/0/0/0",
               name, ready_o, empty_o, full_o, overflow_o, underflow_o, count_o, ramWrAddr_o, ramRdAddr_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; push_i = 1'b0; pop_i = 1'b0; pushTag_i = '0;
    @(negedge clk);
    pulse_reset("reset_state");
    run_init(DEPTH);
  endtask

  task automatic test_overflow();
    cyc(1'b1, 9, 1'b0);
    n_vec++;
    if (ramWe_o !== 1'b0) begin
      n_err++; $display("FAIL overflow_no_write: we=%b want 0", ramWe_o);
    end
    cyc(1'b0, 0, 1'b0);
    n_vec++;
    if (overflow_o !== 1'b1 || count_o !== 7'(p_count) || p_count != DEPTH) begin
      n_err++; $display("FAIL overflow_flag: ovf=%b count=%0d want 1/%0d", overflow_o, count_o, DEPTH);
    end
  endtask

  task automatic test_push_pop_full();
    cyc(1'b1, 5, 1'b1);
    n_vec++;
    if (popTag_o !== WIDTH'(e_tag) || e_tag != INIT_BASE || ramWe_o !== 1'b1
        || ramWrAddr_o !== INDEX'(e_waddr) || ramWrData_o !== 7'd5) begin
      n_err++;
      $display("FAIL full_push_pop: tag=%0d we=%b addr=%0d data=%0d want %0d/1/%0d/5",
               popTag_o, ramWe_o, ramWrAddr_o, ramWrData_o, e_tag, e_waddr);
    end
    cyc(1'b0, 0, 1'b0);
    n_vec++;
    if (count_o !== 7'(DEPTH) || full_o !== 1'b1) begin
      n_err++; $display("FAIL full_push_pop_count: count=%0d full=%b want %0d/1", count_o, full_o, DEPTH);
    end
  endtask

  task automatic test_pop3();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 0, 1'b1);
      n_vec++;
      if (popTag_o !== WIDTH'(e_tag)) begin
        n_err++; $display("FAIL pop3_tag[%0d]: got %0d want %0d", i, popTag_o, e_tag);
      end
    end
    cyc(1'b0, 0, 1'b0);
    n_vec++;
    if (count_o !== 7'(p_count) || p_count != DEPTH - 3 || ramRdAddr_o !== INDEX'(p_head)) begin
      n_err++; $display("FAIL pop3_state: count=%0d head=%0d want %0d/%0d", count_o, ramRdAddr_o, p_count, p_head);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DEPTH && m_q.size() > 0; i++) begin
      cyc(1'b0, 0, 1'b1);
      n_vec++;
      if (popTag_o !== WIDTH'(e_tag)) begin
        n_err++; $display("FAIL drain_tag[%0d]: got %0d want %0d", i, popTag_o, e_tag);
      end
    end
    cyc(1'b0, 0, 1'b1);
    n_vec++;
    if (empty_o !== 1'b1 || count_o !== '0) begin
      n_err++; $display("FAIL drain_empty: empty=%b count=%0d want 1/0", empty_o, count_o);
    end
    cyc(1'b1, 7, 1'b1);
    n_vec++;
    if (underflow_o !== 1'b1 || ramWe_o !== 1'b1 || ramWrData_o !== 7'd7) begin
      n_err++; $display("FAIL underflow_flag: unf=%b we=%b data=%0d want 1/1/7", underflow_o, ramWe_o, ramWrData_o);
    end
    cyc(1'b0, 0, 1'b0);
    n_vec++;
    if (popTag_o !== 7'd7 || count_o !== 7'd1 || empty_o !== 1'b0 || underflow_o !== 1'b1) begin
      n_err++; $display("FAIL no_bypass: tag=%0d count=%0d empty=%b unf=%b want 7/1/0/1",
                        popTag_o, count_o, empty_o, underflow_o);
    end
  endtask

  task automatic test_random_wrap();
    int pp, pq;
    for (int n = 0; n < 3000; n++) begin
      pp = ((n / 150) % 2 == 0) ? 75 : 30;
      pq = 100 - pp;
      cyc($urandom_range(0, 99) < pp, $urandom_range(0, 127), $urandom_range(0, 99) < pq);
      n_vec++;
      if (count_o !== 7'(p_count) || empty_o !== (p_count == 0) || full_o !== (p_count == DEPTH)
          || overflow_o !== p_ovf || underflow_o !== p_unf || ready_o !== 1'b1 || ramRdAddr_o !== INDEX'(p_head)) begin
        n_err++;
        $display("FAIL rand_state n=%0d: count=%0d empty=%b full=%b ovf=%b unf=%b head=%0d want count=%0d ovf=%b unf=%b head=%0d",
                 n, count_o, empty_o, full_o, overflow_o, underflow_o, ramRdAddr_o, p_count, p_ovf, p_unf, p_head);
      end
      n_vec++;
      if (ramWe_o !== e_we || (e_we && (ramWrAddr_o !== INDEX'(e_waddr) || ramWrData_o !== WIDTH'(e_wdata)))) begin
        n_err++;
        $display("FAIL rand_write n=%0d: we=%b addr=%0d data=%0d want %b/%0d/%0d",
                 n, ramWe_o, ramWrAddr_o, ramWrData_o, e_we, e_waddr, e_wdata);
      end
      if (e_tag_valid) begin
        n_vec++;
        if (popTag_o !== WIDTH'(e_tag)) begin
          n_err++; $display("FAIL rand_tag n=%0d: got %0d want %0d", n, popTag_o, e_tag);
        end
      end
    end
    n_vec++;
    if (m_pushes < 2 * DEPTH || m_pops < 2 * DEPTH) begin
      n_err++; $display("FAIL rand_wrap_coverage: pushes=%0d pops=%0d want >=%0d", m_pushes, m_pops, 2 * DEPTH);
    end
  endtask

  task automatic test_reset_mid_init();
    pulse_reset("reset_flags_clear");
    run_init(20);
    pulse_reset("reset_mid_init");
    run_init(DEPTH);
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_push_pop_full();
    test_pop3();
    test_drain_underflow();
    test_random_wrap();
    test_reset_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
